// File: rtl/mandel_pkg.sv
// Shared types and defaults for the Mandelbrot frame scheduler.
package mandel_pkg;

    localparam int COORD_W_DEF = 27;
    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } sched_state_e;

    // Fixed-point 4.23 two's-complement coordinate.
    typedef logic signed [COORD_W_DEF-1:0] coord_t;

endpackage

// File: rtl/mandel_frame_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first eligible requester at or after
// the pointer position. Excluded requesters are never granted.
module mandel_frame_scheduler_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  grant
);

    logic [N-1:0] elig;
    logic         found;

    // Rotating priority search starting at ptr, wrapping modulo N.
    always_comb begin
        elig  = req & ~excl;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && elig[(int'(ptr) + i) % N]) begin
                grant[(int'(ptr) + i) % N] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mandel_frame_scheduler.sv
// Mandelbrot frame scheduler: snapshots the view configuration, walks the
// pixel grid in raster order and hands one job per pixel to an idle solver.
// Optional cycle counter enabled by defining MANDEL_SCHED_PERF_EN.
module mandel_frame_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_SOLVERS = 4,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int H_RES       = H_RES_DEF,
    parameter int V_RES       = V_RES_DEF,
    parameter int X_W         = 10,
    parameter int Y_W         = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [COORD_W-1:0]     cfg_x0,
    input  logic [COORD_W-1:0]     cfg_y0,
    input  logic [COORD_W-1:0]     cfg_step,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_SOLVERS-1:0] solver_busy,
    input  logic [NUM_SOLVERS-1:0] job_ready,
    output logic [NUM_SOLVERS-1:0] job_valid,
    output logic [COORD_W-1:0]     job_cr,
    output logic [COORD_W-1:0]     job_ci,
    output logic [X_W-1:0]         job_px,
    output logic [Y_W-1:0]         job_py,
    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            frame_cycles
);

    localparam int PW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

    sched_state_e state_q, state_d;

    logic signed [COORD_W-1:0] shadow_x0_q, shadow_x0_d;
    logic signed [COORD_W-1:0] shadow_step_q, shadow_step_d;
    logic signed [COORD_W-1:0] cr_q, cr_d;
    logic signed [COORD_W-1:0] ci_q, ci_d;
    logic [X_W-1:0]            px_q, px_d;
    logic [Y_W-1:0]            py_q, py_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [NUM_SOLVERS-1:0]    job_valid_q, job_valid_d;
    logic                      frame_done_q, frame_done_d;

    logic                      hs;
    logic [PW-1:0]             g_idx;
    logic [PW-1:0]             hs_ptr;
    logic                      last_col;
    logic                      last_pixel;
    logic [PW-1:0]             arb_ptr;
    logic [NUM_SOLVERS-1:0]    arb_excl;
    logic [NUM_SOLVERS-1:0]    arb_grant;

    assign hs         = |(job_valid_q & job_ready);
    assign last_col   = (px_q == X_W'(H_RES - 1));
    assign last_pixel = last_col && (py_q == Y_W'(V_RES - 1));

    // Decode the granted solver and the pointer that follows it; on a
    // handshake the same-cycle re-arbitration starts after it and skips it.
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (job_valid_q[i]) g_idx = PW'(i);
        end
        hs_ptr   = (g_idx == PW'(NUM_SOLVERS - 1)) ? '0 : g_idx + PW'(1);
        arb_ptr  = hs ? hs_ptr : ptr_q;
        arb_excl = hs ? job_valid_q : '0;
    end

    mandel_frame_scheduler_rr_arbiter #(
        .N  (NUM_SOLVERS),
        .PW (PW)
    ) u_arb (
        .req   (~solver_busy),
        .ptr   (arb_ptr),
        .excl  (arb_excl),
        .grant (arb_grant)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort overrides everything outside IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start && !abort) state_d = ST_LATCH;
            ST_LATCH:    state_d = abort ? ST_IDLE : ST_DISPATCH;
            ST_DISPATCH: begin
                if (abort)                   state_d = ST_IDLE;
                else if (hs && last_pixel)   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)                   state_d = ST_IDLE;
                else if (solver_busy == '0 && job_valid_q == '0)
                                             state_d = ST_DONE;
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next-values: snapshot, job issue, pixel walk.
    always_comb begin
        shadow_x0_d   = shadow_x0_q;
        shadow_step_d = shadow_step_q;
        cr_d          = cr_q;
        ci_d          = ci_q;
        px_d          = px_q;
        py_d          = py_q;
        ptr_d         = ptr_q;
        job_valid_d   = '0;
        frame_done_d  = (state_d == ST_DONE);
        case (state_q)
            ST_LATCH: begin
                shadow_x0_d   = cfg_x0;
                shadow_step_d = cfg_step;
                cr_d          = cfg_x0;
                ci_d          = cfg_y0;
                px_d          = '0;
                py_d          = '0;
                // First job is offered as soon as DISPATCH is entered.
                job_valid_d   = abort ? '0 : arb_grant;
            end
            ST_DISPATCH: begin
                if (hs) begin
                    ptr_d = hs_ptr;
                    if (last_col) begin
                        px_d = '0;
                        cr_d = shadow_x0_q;
                        py_d = py_q + Y_W'(1);
                        ci_d = ci_q - shadow_step_q;
                    end else begin
                        px_d = px_q + X_W'(1);
                        cr_d = cr_q + shadow_step_q;
                    end
                    job_valid_d = last_pixel ? '0 : arb_grant;
                end else if (job_valid_q == '0) begin
                    job_valid_d = arb_grant;
                end else begin
                    job_valid_d = job_valid_q;
                end
                if (abort) job_valid_d = '0;
            end
            default: job_valid_d = '0;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_x0_q   <= '0;
            shadow_step_q <= '0;
            cr_q          <= '0;
            ci_q          <= '0;
            px_q          <= '0;
            py_q          <= '0;
            ptr_q         <= '0;
            job_valid_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            shadow_x0_q   <= shadow_x0_d;
            shadow_step_q <= shadow_step_d;
            cr_q          <= cr_d;
            ci_q          <= ci_d;
            px_q          <= px_d;
            py_q          <= py_d;
            ptr_q         <= ptr_d;
            job_valid_q   <= job_valid_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign job_valid  = job_valid_q;
    assign job_cr     = cr_q;
    assign job_ci     = ci_q;
    assign job_px     = px_q;
    assign job_py     = py_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

`ifdef MANDEL_SCHED_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] frame_cycles_q, frame_cycles_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count DISPATCH+DRAIN cycles; publish the total when the frame completes.
    always_comb begin
        perf_cnt_d     = perf_cnt_q;
        frame_cycles_d = frame_cycles_q;
        case (state_q)
            ST_LATCH:             perf_cnt_d     = '0;
            ST_DISPATCH, ST_DRAIN: perf_cnt_d    = sat_inc32(perf_cnt_q);
            ST_DONE:              frame_cycles_d = perf_cnt_q;
            default: ;
        endcase
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cnt_q     <= '0;
            frame_cycles_q <= '0;
        end else begin
            perf_cnt_q     <= perf_cnt_d;
            frame_cycles_q <= frame_cycles_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
`else
    assign frame_cycles = '0;
`endif

endmodule

// File: doc/mandel_frame_scheduler.md
Name: mandel_frame_scheduler

Overview:
- Sequences one Mandelbrot frame: snapshots the PIO-driven view configuration (x0, y0, step), walks the pixel grid in raster order and dispatches one (cr, ci, px, py) job per pixel to NUM_SOLVERS iteration engines.
- Shares engines via round-robin arbitration over idle solvers.
- Sits between the HPS-facing PIO slaves and the solver array; status returns through a PIO input.

Parameters:
- NUM_SOLVERS, 4, number of iteration engines (2..16)
- COORD_W, 27, width of the two's-complement fixed-point coordinate (4.23 format)
- H_RES, 640, pixels per row
- V_RES, 480, rows per frame
- X_W, 10, pixel x index width (≥ clog2(H_RES))
- Y_W, 9, pixel y index width (≥ clog2(V_RES))

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cfg_x0  in  COORD_W  real coordinate of pixel (0,0)
- cfg_y0  in  COORD_W  imaginary coordinate of pixel (0,0)
- cfg_step  in  COORD_W  coordinate delta per pixel (both axes)
- start  in  1  level/pulse; sampled only in IDLE
- abort  in  1  cancels frame in progress
- solver_busy  in  NUM_SOLVERS  per-solver busy flag
- job_ready  in  NUM_SOLVERS  per-solver job acceptance
- job_valid  out  NUM_SOLVERS  one-hot or zero, registered
- job_cr  out  COORD_W  shared job real part
- job_ci  out  COORD_W  shared job imaginary part
- job_px  out  X_W  shared job pixel x
- job_py  out  Y_W  shared job pixel y
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse on frame completion
- frame_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Clock clk; reset reset_n, asynchronous, active-low. Reset: state IDLE; all outputs 0; shadow registers, pixel counters and arbiter pointer 0 (pointer favours solver 0 first).
- States IDLE, LATCH, DISPATCH, DRAIN, DONE.
- IDLE: start=1 -> LATCH. start in any other state is ignored.
- LATCH, 1 cycle: shadow_x0/y0/step <= cfg_*; cr <= cfg_x0, ci <= cfg_y0, px=py=0 -> DISPATCH. cfg_* changes after LATCH have no effect on the frame.
- DISPATCH:
  - Arbiter picks the first solver with solver_busy=0, searching from (last_grant+1) mod NUM_SOLVERS.
  - Registered job_valid[g]=1 with job data for the current pixel.
  - job_valid/data stay stable until job_ready[g]=1; valid never depends on ready.
  - On handshake: last_grant <= g, advance the pixel, and in the same cycle re-arbitrate, excluding g, for the next job. Back-to-back one job/cycle is legal.
  - No idle solver: job_valid=0.
- Pixel advance:
  - px<H_RES-1: px+1, cr+=step.
  - Else: px=0, cr=x0, py+1, ci-=step.
  - Arithmetic is modulo 2^COORD_W (wraps, no saturation).
  - Handshake on pixel (H_RES-1, V_RES-1) -> DRAIN.
- DRAIN: wait until solver_busy all 0 and no job_valid -> DONE.
- DONE, 1 cycle: frame_done=1 -> IDLE.
- abort=1 in LATCH/DISPATCH/DRAIN: next cycle state IDLE, job_valid=0, no frame_done. Solvers are not flushed; an in-flight handshake on the abort cycle completes normally.
- abort and start together in IDLE: abort wins (stay IDLE).
- busy is combinational from state; frame_done is registered.

Optional Feature:
- MANDEL_SCHED_PERF_EN defined:
  - 32-bit counter cleared in LATCH, +1 every cycle in DISPATCH/DRAIN, saturating at 0xFFFFFFFF.
  - Copied to frame_cycles on DONE; frame_cycles holds until next DONE; abort leaves it unchanged.
- Undefined: frame_cycles tied to 0, no counter logic.

Decomposition:
- Package mandel_pkg: COORD_W default, H_RES/V_RES defaults, state enum type, coord_t typedef.
- Sub-module rr_arbiter: NUM_SOLVERS request vector, pointer input, one-hot grant, exclusion mask input.

Test Plan:
- Configuration: H_RES=4, V_RES=2, NUM_SOLVERS=2, x0=-2.0 (0x7000000), y0=1.0 (0x0800000), step=0.25 (0x0200000).
- Solvers always ready/idle: 8 jobs on consecutive cycles, alternating solver 0,1; job 4 has cr=-2.0, ci=0.75; frame_done 1 cycle after last drain.
- Solver 1 held busy: all 8 jobs go to solver 0; job_valid held stable 3 cycles while job_ready[0]=0.
- cfg_x0 changed to 0 during DISPATCH: remaining jobs still use -2.0 row base.
- abort after 3rd handshake: job_valid=0 next cycle, busy=0, no frame_done; a new start restarts at px=py=0.
- x0=0x3FFFFFF, step=1 LSB: cr wraps to 0x4000000 on the next pixel.
- With MANDEL_SCHED_PERF_EN and solvers always ready: frame_cycles equals DISPATCH+DRAIN cycle count (e.g. 9); without the macro, frame_cycles stays 0.
